// File: rtl/regfile_pkg.sv
// Shared write-mode encodings and the bit-enable mask helper for regfile_mp_wbq.
// Bit numbering is MSB-0: bit 0 and byte 0 sit at the most significant end.
package regfile_pkg;

    localparam logic [2:0] MODE_A = 3'b000;
    localparam logic [2:0] MODE_U = 3'b001;
    localparam logic [2:0] MODE_D = 3'b010;
    localparam logic [2:0] MODE_E = 3'b011;
    localparam logic [2:0] MODE_O = 3'b100;

    localparam int MAX_W = 256;

    function automatic logic [MAX_W-1:0] sel_mask(input logic [2:0] sel, input int width);
        logic [MAX_W-1:0] m;
        int j;
        m = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width) begin
                // j is the MSB-0 position of vector bit i
                j = width - 1 - i;
                case (sel)
                    MODE_A:  m[i] = 1'b1;
                    MODE_U:  m[i] = j < width / 2;
                    MODE_D:  m[i] = j >= width / 2;
                    MODE_E:  m[i] = ((j / 8) % 2) == 0;
                    MODE_O:  m[i] = ((j / 8) % 2) == 1;
                    default: m[i] = 1'b0;
                endcase
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/regfile_wbq.sv
// Load write-back queue: synchronous FIFO of {sel, addr, data} entries.
// Caller guarantees no push when full and no pop when empty.
module regfile_wbq
    import regfile_pkg::*;
#(
    parameter int DW    = 64,
    parameter int AW    = 5,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [2:0]    in_sel,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_data,
    output logic [2:0]    head_sel,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data,
    output logic [CW-1:0] count
);

    logic [2:0]    q_sel  [DEPTH];
    logic [AW-1:0] q_addr [DEPTH];
    logic [DW-1:0] q_data [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            q_sel[wr_ptr]  <= in_sel;
            q_addr[wr_ptr] <= in_addr;
            q_data[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_sel  = q_sel[rd_ptr];
    assign head_addr = q_addr[rd_ptr];
    assign head_data = q_data[rd_ptr];

endmodule

// File: rtl/regfile_mp_wbq.sv
// Multi-read-port register file with masked ALU writes, a load write-back
// queue, per-register load scoreboard and full same-cycle forwarding.
module regfile_mp_wbq
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int WBQ_DEPTH  = 4,
    localparam int CW        = $clog2(WBQ_DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           we,
    input  logic [2:0]                     wr_sel,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic                           ld_valid,
    output logic                           ld_ready,
    input  logic [2:0]                     ld_sel,
    input  logic [ADDR_WIDTH-1:0]          ld_addr,
    input  logic [DATA_WIDTH-1:0]          ld_data,
    input  logic                           iss_valid,
    input  logic [ADDR_WIDTH-1:0]          iss_addr,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
    output logic [NUM_RD-1:0]              rd_pending,
    output logic [CW-1:0]                  wbq_count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [CW-1:0] FULL = CW'(WBQ_DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      pending;
    logic [DEPTH-1:0]      pending_n;

    logic [2:0]            head_sel;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;
    logic [DATA_WIDTH-1:0] head_mask;
    logic [DATA_WIDTH-1:0] wr_mask;
    logic                  push;
    logic                  pop;
    logic                  alu_wr;
    logic                  head_wr;

    assign ld_ready  = wbq_count < FULL;
    assign push      = ld_valid && ld_ready;
    // Head yields to an ALU write to the same register, so the load lands last
    assign pop       = (wbq_count != '0) && !(we && wr_addr == head_addr);
    assign alu_wr    = we && wr_addr != '0;
    assign head_wr   = pop && head_addr != '0;
    assign wr_mask   = DATA_WIDTH'(sel_mask(wr_sel, DATA_WIDTH));
    assign head_mask = DATA_WIDTH'(sel_mask(head_sel, DATA_WIDTH));

    regfile_wbq #(
        .DW    (DATA_WIDTH),
        .AW    (ADDR_WIDTH),
        .DEPTH (WBQ_DEPTH)
    ) u_wbq (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .in_sel    (ld_sel),
        .in_addr   (ld_addr),
        .in_data   (ld_data),
        .head_sel  (head_sel),
        .head_addr (head_addr),
        .head_data (head_data),
        .count     (wbq_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
        end else begin
            if (head_wr)
                mem[head_addr] <= (mem[head_addr] & ~head_mask) | (head_data & head_mask);
            if (alu_wr)
                mem[wr_addr] <= (mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
        end
    end

    always_comb begin
        pending_n = pending;
        if (pop) pending_n[head_addr] = 1'b0;
        if (iss_valid && iss_addr != '0) pending_n[iss_addr] = 1'b1;
        pending_n[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pending <= '0;
        else       pending <= pending_n;
    end

    a_iss_not_pending: assert property (@(posedge clk) disable iff (reset)
        !(iss_valid && iss_addr != '0 && pending[iss_addr]
          && !(pop && head_addr == iss_addr)));

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] v;
        assign a = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        always_comb begin
            v = mem[a];
            if (pop && head_addr == a) v = (v & ~head_mask) | (head_data & head_mask);
            if (we && wr_addr == a)    v = (v & ~wr_mask) | (wr_data & wr_mask);
            if (a == '0)               v = '0;
        end
        assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = v;
        assign rd_pending[i] = (a != '0) && pending[a] && !(pop && head_addr == a);
    end

endmodule
